// File: rtl/wm8750_pkg.sv
// Shared constants and FSM state encoding for the WM8750 control-port responder.
package wm8750_pkg;

   localparam logic [6:0] DEV_ADDR_DEF = 7'h1A;
   localparam logic [6:0] REG_RESET    = 7'd15;
   localparam int         REG_ADDR_W   = 7;
   localparam int         DATA_W       = 9;
   localparam int         NUM_REGS     = 128;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      BYTE0,
      ACK0,
      BYTE1,
      ACK1,
      IGNORE
   } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus glitch filter for one open-drain I2C line; emits the
// filtered level and one-cycle rise/fall pulses.
module i2c_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic osc_clk,
   input  logic reset_,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic [FILT_LEN-1:0]    hist;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge osc_clk or negedge reset_) begin
      if (!reset_) begin
         sync  <= '1;
         hist  <= '1;
         level <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], line_in};
         hist <= {hist[FILT_LEN-2:0], sync[SYNC_STAGES-1]};
         rise <= 1'b0;
         fall <= 1'b0;
         // A new level is accepted only once the whole history window agrees.
         if ((&hist) && !level) begin
            level <= 1'b1;
            rise  <= 1'b1;
         end else if (!(|hist) && level) begin
            level <= 1'b0;
            fall  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/wm8750_i2c_responder.sv
// Write-only I2C target mirroring the WM8750 control port: ACKs writes to
// DEV_ADDR, decodes 16-bit register words and keeps a 128x9 shadow file.
module wm8750_i2c_responder
   import wm8750_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEF,
   parameter int         SYNC_STAGES = 2,
   parameter int         FILT_LEN    = 3
) (
   input  logic                  osc_clk,
   input  logic                  reset_,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic                  wr_valid,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0]     wr_data,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic [7:0]            nack_cnt
);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
      .osc_clk (osc_clk),
      .reset_  (reset_),
      .line_in (scl_in),
      .level   (scl),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
      .osc_clk (osc_clk),
      .reset_  (reset_),
      .line_in (sda_in),
      .level   (sda),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   state_t                  state;
   logic [3:0]              bit_cnt;
   logic [7:0]              shreg;
   logic [7:0]              byte0;
   logic [DATA_W-1:0]       shadow [NUM_REGS];
   logic                    start, stop, byte_done, commit;
   logic [REG_ADDR_W-1:0]   commit_addr;
   logic [DATA_W-1:0]       commit_data;

   assign start       = sda_fall & scl;
   assign stop        = sda_rise & scl;
   assign byte_done   = scl_fall & (bit_cnt == 4'd8) & ~start & ~stop;
   assign commit      = byte_done & (state == BYTE1);
   assign commit_addr = byte0[7:1];
   assign commit_data = {byte0[0], shreg};

   // sda_oe is only ever changed on a filtered SCL fall, so the target never
   // moves SDA while SCL is high.
   always_ff @(posedge osc_clk or negedge reset_) begin
      if (!reset_) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         byte0    <= '0;
         sda_oe   <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         nack_cnt <= '0;
      end else begin
         wr_valid <= 1'b0;
         if (start) begin
            state   <= ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
         end else if (stop) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
         end else begin
            case (state)
               ADDR, BYTE0, BYTE1: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[6:0], sda};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (byte_done) begin
                     bit_cnt <= '0;
                     if (state == ADDR) begin
                        if (shreg == {DEV_ADDR, 1'b0}) begin
                           state  <= ADDR_ACK;
                           sda_oe <= 1'b1;
                        end else begin
                           state <= IGNORE;
                           if (shreg[7:1] == DEV_ADDR && nack_cnt != 8'hFF)
                              nack_cnt <= nack_cnt + 8'd1;
                        end
                     end else if (state == BYTE0) begin
                        byte0  <= shreg;
                        state  <= ACK0;
                        sda_oe <= 1'b1;
                     end else begin
                        wr_addr  <= commit_addr;
                        wr_data  <= commit_data;
                        wr_valid <= 1'b1;
                        state    <= ACK1;
                        sda_oe   <= 1'b1;
                     end
                  end
               end
               ADDR_ACK, ACK0, ACK1: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= (state == ACK0) ? BYTE1 : BYTE0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: the shadow file is flop-based and must read back as zero after reset, so it is reset explicitly.
   always_ff @(posedge osc_clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
         rd_data <= '0;
      end else begin
         rd_data <= shadow[rd_addr];
         if (commit) begin
            if (commit_addr == REG_RESET) begin
               for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
               shadow[REG_RESET] <= commit_data;
            end else begin
               shadow[commit_addr] <= commit_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_wm8750_i2c_responder.sv
// Directed bench: bit-banged I2C initiator against the WM8750 responder.
module tb_wm8750_i2c_responder;

   logic       osc_clk = 1'b0;
   logic       reset_  = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       scl_in, sda_in, sda_oe, wr_valid;
   logic [6:0] wr_addr, rd_addr;
   logic [8:0] wr_data, rd_data;
   logic [7:0] nack_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int q     = 10;

   int         wv_cnt  = 0;
   int         oe_rise = 0;
   int         oe_viol = 0;
   logic       prev_oe = 1'b0;
   logic [6:0] log_addr [32];
   logic [8:0] log_data [32];
   logic [8:0] log_rd   [32];

   int base_wv, base_oe;

   assign scl_in = scl_drv;
   assign sda_in = sda_drv & ~sda_oe;

   always #5 osc_clk = ~osc_clk;

   wm8750_i2c_responder dut (
      .osc_clk  (osc_clk),
      .reset_   (reset_),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda_oe   (sda_oe),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .nack_cnt (nack_cnt)
   );

   always @(negedge osc_clk) begin
      if (wr_valid) begin
         if (wv_cnt < 32) begin
            log_addr[wv_cnt] = wr_addr;
            log_data[wv_cnt] = wr_data;
            log_rd[wv_cnt]   = rd_data;
         end
         wv_cnt++;
      end
      if (reset_ && sda_oe && !prev_oe) oe_rise++;
      if (reset_ && sda_oe !== prev_oe && scl_in) oe_viol++;
      prev_oe = sda_oe;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge osc_clk);
   endtask

   task automatic wait_q(input int n);
      wait_clk(n * q);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; wait_q(1);
      scl_drv = 1'b1; wait_q(1);
      sda_drv = 1'b0; wait_q(1);
      scl_drv = 1'b0; wait_q(1);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wait_q(1);
      scl_drv = 1'b1; wait_q(1);
      sda_drv = 1'b1; wait_q(1);
   endtask

   // glitch adds a 1-cycle SCL spike while low and a 1-cycle SDA flip while high
   task automatic send_bit(input logic b, input bit glitch);
      sda_drv = b; wait_q(1);
      if (glitch) begin
         scl_drv = 1'b1; wait_clk(1);
         scl_drv = 1'b0; wait_q(1);
      end
      scl_drv = 1'b1; wait_q(1);
      if (glitch) begin
         sda_drv = ~b; wait_clk(1);
         sda_drv = b;
      end
      wait_q(1);
      scl_drv = 1'b0; wait_q(1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack, input bit glitch, input string tag);
      for (int i = 7; i >= 0; i--) send_bit(b[i], glitch && (i == 3));
      sda_drv = 1'b1; wait_q(1);
      scl_drv = 1'b1; wait_q(1);
      chk({tag, " ack"}, {31'd0, ~sda_in}, {31'd0, exp_ack});
      wait_q(1);
      scl_drv = 1'b0; wait_q(1);
   endtask

   task automatic rd_chk(input logic [6:0] a, input logic [8:0] exp, input string tag);
      rd_addr = a;
      wait_clk(2);
      chk(tag, {23'd0, rd_data}, {23'd0, exp});
   endtask

   task automatic mark();
      base_wv = wv_cnt;
      base_oe = oe_rise;
   endtask

   initial begin
      rd_addr = 7'd5;
      wait_clk(5);
      chk("rst sda_oe", {31'd0, sda_oe}, 32'd0);
      chk("rst wr_valid", {31'd0, wr_valid}, 32'd0);
      chk("rst wr_addr", {25'd0, wr_addr}, 32'd0);
      chk("rst wr_data", {23'd0, wr_data}, 32'd0);
      chk("rst nack_cnt", {24'd0, nack_cnt}, 32'd0);
      chk("rst rd_data", {23'd0, rd_data}, 32'd0);
      reset_ = 1'b1;
      wait_q(2);

      // basic write: reg 5 <= 0x1FF
      mark();
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "w1 addr");
      send_byte(8'h0B, 1'b1, 1'b0, "w1 b0");
      send_byte(8'hFF, 1'b1, 1'b0, "w1 b1");
      i2c_stop();
      chk("w1 acks", oe_rise - base_oe, 32'd3);
      chk("w1 wv pulses", wv_cnt - base_wv, 32'd1);
      chk("w1 log addr", {25'd0, log_addr[base_wv]}, 32'h05);
      chk("w1 log data", {23'd0, log_data[base_wv]}, 32'h1FF);
      chk("w1 wr_addr", {25'd0, wr_addr}, 32'h05);
      chk("w1 wr_data", {23'd0, wr_data}, 32'h1FF);
      rd_chk(7'd5, 9'h1FF, "w1 shadow5");

      // other device address
      mark();
      i2c_start();
      send_byte(8'h36, 1'b0, 1'b0, "oth addr");
      send_byte(8'hAA, 1'b0, 1'b0, "oth b0");
      send_byte(8'h55, 1'b0, 1'b0, "oth b1");
      i2c_stop();
      chk("oth acks", oe_rise - base_oe, 32'd0);
      chk("oth wv", wv_cnt - base_wv, 32'd0);
      chk("oth nack_cnt", {24'd0, nack_cnt}, 32'd0);

      // read requests are NACKed and counted, saturating at 255
      mark();
      i2c_start();
      send_byte(8'h35, 1'b0, 1'b0, "rd addr");
      i2c_stop();
      chk("rd nack 1", {24'd0, nack_cnt}, 32'd1);
      q = 5;
      for (int i = 0; i < 254; i++) begin
         i2c_start(); send_byte(8'h35, 1'b0, 1'b0, "rd loop"); i2c_stop();
      end
      chk("rd nack 255", {24'd0, nack_cnt}, 32'd255);
      for (int i = 0; i < 45; i++) begin
         i2c_start(); send_byte(8'h35, 1'b0, 1'b0, "rd sat"); i2c_stop();
      end
      q = 10;
      chk("rd nack sat", {24'd0, nack_cnt}, 32'd255);
      chk("rd acks", oe_rise - base_oe, 32'd0);

      // two words in one transaction
      mark();
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "w2 addr");
      send_byte(8'h0E, 1'b1, 1'b0, "w2 b0");
      send_byte(8'h02, 1'b1, 1'b0, "w2 b1");
      send_byte(8'h10, 1'b1, 1'b0, "w2 b2");
      send_byte(8'h55, 1'b1, 1'b0, "w2 b3");
      i2c_stop();
      chk("w2 acks", oe_rise - base_oe, 32'd5);
      chk("w2 wv", wv_cnt - base_wv, 32'd2);
      chk("w2 c0 addr", {25'd0, log_addr[base_wv]}, 32'h07);
      chk("w2 c0 data", {23'd0, log_data[base_wv]}, 32'h002);
      chk("w2 c1 addr", {25'd0, log_addr[base_wv+1]}, 32'h08);
      chk("w2 c1 data", {23'd0, log_data[base_wv+1]}, 32'h055);
      rd_chk(7'd7, 9'h002, "w2 shadow7");
      rd_chk(7'd8, 9'h055, "w2 shadow8");

      // STOP in the middle of BYTE1 discards the word
      mark();
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "part addr");
      send_byte(8'h0B, 1'b1, 1'b0, "part b0");
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
      i2c_stop();
      chk("part wv", wv_cnt - base_wv, 32'd0);
      rd_chk(7'd5, 9'h1FF, "part shadow5");
      // follow-up write; rd_addr stays 5 so the commit cycle shows the old value
      mark();
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "w3 addr");
      send_byte(8'h0A, 1'b1, 1'b0, "w3 b0");
      send_byte(8'h12, 1'b1, 1'b0, "w3 b1");
      i2c_stop();
      chk("w3 wv", wv_cnt - base_wv, 32'd1);
      chk("w3 data", {23'd0, log_data[base_wv]}, 32'h012);
      chk("w3 rd old", {23'd0, log_rd[base_wv]}, 32'h1FF);
      rd_chk(7'd5, 9'h012, "w3 shadow5");

      // glitches on SCL and SDA mid-byte
      mark();
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b1, "gl addr");
      send_byte(8'h0C, 1'b1, 1'b1, "gl b0");
      send_byte(8'h21, 1'b1, 1'b1, "gl b1");
      i2c_stop();
      chk("gl acks", oe_rise - base_oe, 32'd3);
      chk("gl wv", wv_cnt - base_wv, 32'd1);
      chk("gl addr", {25'd0, log_addr[base_wv]}, 32'h06);
      chk("gl data", {23'd0, log_data[base_wv]}, 32'h021);

      // repeated START after BYTE0 restarts at ADDR
      mark();
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "rs addr");
      send_byte(8'h0D, 1'b1, 1'b0, "rs b0");
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "rs addr2");
      send_byte(8'h0D, 1'b1, 1'b0, "rs b0b");
      send_byte(8'h33, 1'b1, 1'b0, "rs b1");
      i2c_stop();
      chk("rs acks", oe_rise - base_oe, 32'd5);
      chk("rs wv", wv_cnt - base_wv, 32'd1);
      chk("rs addr", {25'd0, log_addr[base_wv]}, 32'h06);
      chk("rs data", {23'd0, log_data[base_wv]}, 32'h133);

      // asynchronous reset while the address ACK is driven with SCL high
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(logic'(8'h34 >> i), 1'b0);
      sda_drv = 1'b1; wait_q(1);
      scl_drv = 1'b1; wait_q(1);
      chk("ar oe before", {31'd0, sda_oe}, 32'd1);
      reset_ = 1'b0;
      #1;
      chk("ar oe immediate", {31'd0, sda_oe}, 32'd0);
      wait_clk(3);
      chk("ar nack_cnt", {24'd0, nack_cnt}, 32'd0);
      scl_drv = 1'b0; wait_q(1);
      reset_ = 1'b1;
      wait_q(2);
      rd_chk(7'd6, 9'h000, "ar shadow6");
      mark();
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "ar addr");
      send_byte(8'h0B, 1'b1, 1'b0, "ar b0");
      send_byte(8'h07, 1'b1, 1'b0, "ar b1");
      i2c_stop();
      chk("ar wv", wv_cnt - base_wv, 32'd1);
      rd_chk(7'd5, 9'h107, "ar shadow5");

      // reg 15 write clears the file and keeps the written value
      mark();
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "r15 addr");
      send_byte(8'h1E, 1'b1, 1'b0, "r15 b0");
      send_byte(8'h5A, 1'b1, 1'b0, "r15 b1");
      i2c_stop();
      chk("r15 wv", wv_cnt - base_wv, 32'd1);
      rd_chk(7'd5, 9'h000, "r15 shadow5");
      rd_chk(7'd15, 9'h05A, "r15 shadow15");

      chk("oe only while scl low", oe_viol, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
